// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate/data extension stage feeding a DEPTH-entry output FIFO.
// Only extended results and their illegal-op flag are buffered, never raw operands.
module ext_pipe #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_W-1:0]        in_imm,
   input  logic [2:0]             in_op,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_err,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned SH = OUT_W - IN_W;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [OUT_W-1:0] w_sext;
   logic [OUT_W-1:0] w_ext;
   logic             w_err;
   logic             w_push;
   logic             w_pop;

   logic [OUT_W:0]   r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   always_comb begin
      w_sext = {{SH{in_imm[IN_W-1]}}, in_imm};
      w_ext  = '0;
      w_err  = 1'b0;
      case (in_op)
         3'd0:    w_ext = {{SH{1'b0}}, in_imm};
         3'd1:    w_ext = {in_imm, {SH{1'b0}}};
         3'd2:    w_ext = w_sext;
         3'd3:    w_ext = {w_sext[OUT_W-3:0], 2'b00};
         3'd4:    w_ext = {{(OUT_W-8){in_imm[7]}}, in_imm[7:0]};
         3'd5:    w_ext = {{(OUT_W-8){1'b0}}, in_imm[7:0]};
         3'd6:    w_ext = {{SH{1'b1}}, in_imm};
         default: w_err = 1'b1;
      endcase
   end

   assign in_ready  = (r_count != CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign count     = r_count;

   // Empty buffer shows zeros so the unreset storage never leaks to the outputs.
   assign out_data = out_valid ? r_mem[r_rptr][OUT_W-1:0] : '0;
   assign out_err  = out_valid ? r_mem[r_rptr][OUT_W]     : 1'b0;

   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         r_mem[r_wptr] <= {w_err, w_ext};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed scenarios plus randomized traffic against a
// queue-based reference model whose extension rules use plain integer arithmetic.
module tb_ext_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Default instance: IN_W=16, OUT_W=32, DEPTH=2
   logic        m_flush = 0, m_valid = 0, m_ready, m_ovalid, m_ordy = 0, m_err;
   logic [15:0] m_imm = '0;
   logic [2:0]  m_op = '0;
   logic [31:0] m_data;
   logic [1:0]  m_count;

   // DEPTH=4 instance
   logic        f_flush = 0, f_valid = 0, f_ready, f_ovalid, f_ordy = 0, f_err;
   logic [15:0] f_imm = '0;
   logic [2:0]  f_op = '0;
   logic [31:0] f_data;
   logic [2:0]  f_count;

   // IN_W=8, OUT_W=16 instance
   logic        n_flush = 0, n_valid = 0, n_ready, n_ovalid, n_ordy = 0, n_err;
   logic [7:0]  n_imm = '0;
   logic [2:0]  n_op = '0;
   logic [15:0] n_data;
   logic [1:0]  n_count;

   ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(m_flush), .in_valid(m_valid), .in_ready(m_ready),
      .in_imm(m_imm), .in_op(m_op), .out_valid(m_ovalid), .out_ready(m_ordy),
      .out_data(m_data), .out_err(m_err), .count(m_count));

   ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(f_flush), .in_valid(f_valid), .in_ready(f_ready),
      .in_imm(f_imm), .in_op(f_op), .out_valid(f_ovalid), .out_ready(f_ordy),
      .out_data(f_data), .out_err(f_err), .count(f_count));

   ext_pipe #(.IN_W(8), .OUT_W(16), .DEPTH(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .flush(n_flush), .in_valid(n_valid), .in_ready(n_ready),
      .in_imm(n_imm), .in_op(n_op), .out_valid(n_ovalid), .out_ready(n_ordy),
      .out_data(n_data), .out_err(n_err), .count(n_count));

   // Returns {err, data}; data is the mathematical result reduced modulo 2^outw.
   function automatic logic [32:0] ref_ext(input int unsigned imm, input int op,
                                           input int inw, input int outw);
      longint v, m, s, b, r;
      v = longint'(imm);
      m = (longint'(1) << outw) - 1;
      s = (((v >> (inw - 1)) & 1) == 1) ? v - (longint'(1) << inw) : v;
      b = v & 255;
      if (b >= 128) b = b - 256;
      r = 0;
      case (op)
         0: r = v;
         1: r = v << (outw - inw);
         2: r = s;
         3: r = s * 4;
         4: r = b;
         5: r = v & 255;
         6: r = v + (longint'(1) << outw) - (longint'(1) << inw);
         default: return {1'b1, 32'h0};
      endcase
      return {1'b0, 32'(r & m)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_checks++;
      if (m_ovalid !== 1'b0 || m_count !== 2'd0 || m_ready !== 1'b1 ||
          m_data !== 32'h0 || m_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset: ovalid=%b count=%0d ready=%b data=%h err=%b, want 0 0 1 0 0",
                  m_ovalid, m_count, m_ready, m_data, m_err);
      end
   endtask

   task automatic test_modes();
      logic [31:0] exp [8];
      exp[0] = 32'h00008001; exp[1] = 32'h80010000; exp[2] = 32'hFFFF8001;
      exp[3] = 32'hFFFE0004; exp[4] = 32'h00000001; exp[5] = 32'h00000001;
      exp[6] = 32'hFFFF8001; exp[7] = 32'h00000000;
      m_ordy = 1; m_imm = 16'h8001;
      for (int i = 0; i < 9; i++) begin
         m_valid = (i < 8);
         m_op = 3'(i);
         if (i > 0) begin
            n_checks++;
            if (m_ovalid !== 1'b1 || m_data !== exp[i-1] || m_err !== (i == 8) ||
                m_count !== 2'd1) begin
               n_errors++;
               $display("FAIL mode%0d: valid=%b data=%h err=%b count=%0d, want 1 %h %b 1",
                        i - 1, m_ovalid, m_data, m_err, m_count, exp[i-1], (i == 8));
            end
         end
         cyc();
      end
      m_valid = 0;
      n_checks++;
      if (m_ovalid !== 1'b0 || m_count !== 2'd0) begin
         n_errors++;
         $display("FAIL modes_drain: valid=%b count=%0d, want 0 0", m_ovalid, m_count);
      end
   endtask

   task automatic test_backpressure();
      m_ordy = 0; m_op = 3'd2; m_valid = 1;
      m_imm = 16'h0010; cyc();
      m_imm = 16'h00F0; cyc();
      n_checks++;
      if (m_count !== 2'd2 || m_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_full: count=%0d ready=%b, want 2 0", m_count, m_ready);
      end
      m_imm = 16'h00AB; m_op = 3'd0; cyc();
      n_checks++;
      if (m_count !== 2'd2 || m_data !== 32'h10) begin
         n_errors++;
         $display("FAIL bp_hold: count=%0d data=%h, want 2 00000010", m_count, m_data);
      end
      m_valid = 0; m_ordy = 1;
      n_checks++;
      if (m_ovalid !== 1'b1 || m_data !== 32'h10) begin
         n_errors++;
         $display("FAIL bp_first: valid=%b data=%h, want 1 00000010", m_ovalid, m_data);
      end
      cyc();
      n_checks++;
      if (m_ovalid !== 1'b1 || m_data !== 32'hF0 || m_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_second: valid=%b data=%h ready=%b, want 1 000000f0 1",
                  m_ovalid, m_data, m_ready);
      end
      cyc();
      n_checks++;
      if (m_ovalid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_empty: valid=%b, want 0", m_ovalid);
      end
      m_valid = 1; cyc(); m_valid = 0;
      n_checks++;
      if (m_ovalid !== 1'b1 || m_data !== 32'hAB) begin
         n_errors++;
         $display("FAIL bp_third: valid=%b data=%h, want 1 000000ab", m_ovalid, m_data);
      end
      cyc();
   endtask

   task automatic test_flush();
      m_ordy = 0; m_op = 3'd0; m_valid = 1;
      m_imm = 16'h0001; cyc();
      m_imm = 16'h0002; cyc();
      m_flush = 1; m_imm = 16'h0055; cyc();
      m_flush = 0; m_valid = 0;
      n_checks++;
      if (m_count !== 2'd0 || m_ovalid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush: count=%0d valid=%b, want 0 0", m_count, m_ovalid);
      end
      m_ordy = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++;
         if (m_ovalid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_ghost: valid=%b data=%h, want 0", m_ovalid, m_data);
         end
      end
   endtask

   task automatic test_random();
      logic [32:0] q[$];
      logic [32:0] e;
      bit push, pop;
      for (int c = 0; c < 400; c++) begin
         m_valid = 1'($urandom_range(0, 1));
         m_op    = 3'($urandom_range(0, 7));
         m_imm   = 16'($urandom);
         m_ordy  = ($urandom_range(0, 3) != 0);
         m_flush = ($urandom_range(0, 24) == 0);
         n_checks++;
         if (m_ready !== (q.size() != 2) || m_ovalid !== (q.size() != 0) ||
             int'(m_count) !== q.size()) begin
            n_errors++;
            $display("FAIL rand_state c=%0d: ready=%b valid=%b count=%0d, want size %0d",
                     c, m_ready, m_ovalid, m_count, q.size());
         end
         if (q.size() != 0) begin
            n_checks++;
            if ({m_err, m_data} !== q[0]) begin
               n_errors++;
               $display("FAIL rand_data c=%0d: got %b/%h want %b/%h",
                        c, m_err, m_data, q[0][32], q[0][31:0]);
            end
         end
         push = m_valid && (q.size() != 2);
         pop  = (q.size() != 0) && m_ordy;
         e = ref_ext(32'(m_imm), int'(m_op), 16, 32);
         @(posedge clk);
         if (m_flush) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
         end
         @(negedge clk);
      end
      m_flush = 0; m_valid = 0; m_ordy = 1;
      cyc(); cyc(); cyc();
   endtask

   task automatic test_reset_mid();
      m_ordy = 0; m_op = 3'd0; m_valid = 1;
      m_imm = 16'h0011; cyc();
      m_imm = 16'h0022; cyc();
      m_valid = 0;
      #2 rst_n = 0;
      #1;
      n_checks++;
      if (m_ovalid !== 1'b0 || m_count !== 2'd0 || m_data !== 32'h0) begin
         n_errors++;
         $display("FAIL rst_mid: valid=%b count=%0d data=%h, want 0 0 0",
                  m_ovalid, m_count, m_data);
      end
      rst_n = 1;
      #0.5;
      n_checks++;
      if (m_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_ready: ready=%b, want 1", m_ready);
      end
      @(negedge clk);
      m_valid = 1; m_imm = 16'h1234; cyc(); m_valid = 0;
      n_checks++;
      if (m_ovalid !== 1'b1 || m_data !== 32'h1234 || m_count !== 2'd1) begin
         n_errors++;
         $display("FAIL rst_latency: valid=%b data=%h count=%0d, want 1 00001234 1",
                  m_ovalid, m_data, m_count);
      end
      m_ordy = 1; cyc();
   endtask

   task automatic test_wrap();
      logic [31:0] q[$];
      int sent = 0, got = 0, c = 0;
      bit push, pop;
      f_op = 3'd0;
      while (got < 20 && c < 200) begin
         f_valid = (sent < 20);
         f_imm   = 16'(sent + 1);
         f_ordy  = (c % 2 == 1);
         n_checks++;
         if (int'(f_count) !== q.size() || f_count > 3'd4 || f_ovalid !== (q.size() != 0) ||
             f_ready !== (q.size() != 4)) begin
            n_errors++;
            $display("FAIL wrap_state c=%0d: count=%0d valid=%b ready=%b, want size %0d",
                     c, f_count, f_ovalid, f_ready, q.size());
         end
         if (q.size() != 0 && f_ordy) begin
            n_checks++;
            if (f_data !== q[0]) begin
               n_errors++;
               $display("FAIL wrap_data: got %h want %h", f_data, q[0]);
            end
         end
         push = f_valid && (q.size() != 4);
         pop  = (q.size() != 0) && f_ordy;
         @(posedge clk);
         if (pop) begin void'(q.pop_front()); got++; end
         if (push) begin q.push_back(32'(sent + 1)); sent++; end
         @(negedge clk);
         c++;
      end
      f_valid = 0;
      n_checks++;
      if (got != 20) begin
         n_errors++;
         $display("FAIL wrap_timeout: got %0d beats, want 20", got);
      end
   endtask

   task automatic test_generics();
      logic [15:0] exp [3];
      logic [2:0]  ops [3];
      logic [32:0] prev;
      exp[0] = 16'hFF9C; exp[1] = 16'h9C00; exp[2] = 16'hFE70;
      ops[0] = 3'd2; ops[1] = 3'd1; ops[2] = 3'd3;
      n_ordy = 1; n_imm = 8'h9C;
      for (int i = 0; i < 4; i++) begin
         n_valid = (i < 3);
         n_op = ops[i % 3];
         if (i > 0) begin
            n_checks++;
            if (n_ovalid !== 1'b1 || n_data !== exp[i-1] || n_err !== 1'b0) begin
               n_errors++;
               $display("FAIL gen_op%0d: valid=%b data=%h err=%b, want 1 %h 0",
                        ops[i-1], n_ovalid, n_data, n_err, exp[i-1]);
            end
         end
         cyc();
      end
      prev = '0;
      for (int i = 0; i < 41; i++) begin
         n_valid = (i < 40);
         n_op = 3'($urandom_range(0, 7));
         n_imm = 8'($urandom);
         if (i > 0) begin
            n_checks++;
            if (n_ovalid !== 1'b1 || {n_err, n_data} !== {prev[32], prev[15:0]}) begin
               n_errors++;
               $display("FAIL gen_rand%0d: got %b/%h want %b/%h",
                        i, n_err, n_data, prev[32], prev[15:0]);
            end
         end
         prev = ref_ext(32'(n_imm), int'(n_op), 8, 16);
         cyc();
      end
      n_valid = 0;
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      test_reset();
      test_modes();
      test_backpressure();
      test_flush();
      test_random();
      test_reset_mid();
      test_wrap();
      test_generics();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
